// File: rtl/host_regbank_seg_pkg.sv
// ---------------------------------------------------------------------------
// host_regbank_seg_pkg
//   Shared constants for the host register bank slice:
//   - host byte addresses of the command/status/result registers
//   - bit positions inside the STATUS word
//   - hex nibble to 7-segment (a..g) encoder
// ---------------------------------------------------------------------------
package host_regbank_seg_pkg;

    // Host byte addresses (HOST_ADD[19:0]); constant regs live at 0x00000 + 4*i
    localparam logic [19:0] ADDR_CMD     = 20'h01000;
    localparam logic [19:0] ADDR_STATUS  = 20'h01002;
    localparam logic [19:0] ADDR_DOUT_LO = 20'h01004;
    localparam logic [19:0] ADDR_DOUT_HI = 20'h01006;

    // STATUS word layout
    localparam int ST_VALID   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_BUSY    = 2;

    // Hex digit to segments, returned as {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/host_regbank_seg_seg_scan.sv
// ---------------------------------------------------------------------------
// host_regbank_seg_seg_scan
//   Multiplexed hex 7-segment scanner. A free-running divider produces a
//   tick every SCAN_DIV clocks; on each tick the current digit index is
//   shown (its nibble decoded, its common line pulled low) and the index
//   advances. Outputs keep their reset values until the first tick.
// Ports
//   clk         in   system clock
//   nRESET      in   async active-low reset
//   din_i       in   4*NUM_DIGITS  nibbles to display, digit k = din_i[4k+3:4k]
//   seg_com_o   out  NUM_DIGITS    active-low one-hot digit enable
//   seg_data_o  out  8             {a,b,c,d,e,f,g,dp}, active high, dp = 0
// ---------------------------------------------------------------------------
module host_regbank_seg_seg_scan
    import host_regbank_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 25000
) (
    input  logic                      clk,
    input  logic                      nRESET,
    input  logic [4*NUM_DIGITS-1:0]   din_i,
    output logic [NUM_DIGITS-1:0]     seg_com_o,
    output logic [7:0]                seg_data_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;
    logic [7:0]            data_q, data_d;
    logic                  tick;
    logic [3:0]            nib;

    assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

    // Nibble for the current index, selected with constant slices
    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (idx_q == IDX_W'(k)) nib = din_i[4*k +: 4];
    end

    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        idx_d  = idx_q;
        com_d  = com_q;
        data_d = data_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            // digit 0 drives the leftmost common line (MSB)
            for (int k = 0; k < NUM_DIGITS; k++)
                com_d[k] = (idx_q != IDX_W'(NUM_DIGITS - 1 - k));
            data_d = {hex7seg(nib), 1'b0};
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            com_q  <= '1;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            com_q  <= com_d;
            data_q <= data_d;
        end
    end

    assign seg_com_o  = com_q;
    assign seg_data_o = data_q;

endmodule

// File: rtl/host_regbank_seg.sv
// ---------------------------------------------------------------------------
// host_regbank_seg
//   Host-bus slave between the M1 host bus and the processing core:
//   NUM_REGS 32-bit constant registers, a command register handed to the
//   core with valid/ready, readback of everything plus core result/status,
//   and a multiplexed hex display of the core result.
// Ports
//   clk, nRESET          system clock, async active-low reset
//   HOST_nCS/nWE/nOE     host strobes, active low, asynchronous to clk
//   HOST_ADD [20:0]      host byte address, [19:0] decoded
//   HDI [15:0]           host write data
//   HDO [15:0]           registered host read data
//   const_bus            constant regs, reg i at [32i+31:32i]
//   cmd, cmd_valid       command to core, held stable while valid
//   cmd_ready            core accepts when valid & ready
//   proc_dout, proc_busy core result and busy flag
//   SEG_COM, SEG_DATA    7-segment digit enables (active low) and segments
// ---------------------------------------------------------------------------
module host_regbank_seg
    import host_regbank_seg_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 25000,
    parameter int CMD_W      = 4
) (
    input  logic                     clk,
    input  logic                     nRESET,
    input  logic                     HOST_nCS,
    input  logic                     HOST_nWE,
    input  logic                     HOST_nOE,
    input  logic [20:0]              HOST_ADD,
    input  logic [15:0]              HDI,
    output logic [15:0]              HDO,
    output logic [NUM_REGS*32-1:0]   const_bus,
    output logic [CMD_W-1:0]         cmd,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    input  logic [31:0]              proc_dout,
    input  logic                     proc_busy,
    output logic [NUM_DIGITS-1:0]    SEG_COM,
    output logic [7:0]               SEG_DATA
);

    logic [19:0] addr;
    logic        unused_addr_msb;

    assign addr            = HOST_ADD[19:0];
    assign unused_addr_msb = HOST_ADD[20];

    // ---------------------------------------------------------------
    // Write strobe synchroniser and falling-edge detect.
    // Flops reset to 0 ("strobe already asserted") so a strobe that is
    // still low when reset releases cannot fire; a fresh falling edge
    // is required. [1:0] is the 2-flop sync, [2] is the edge history.
    // ---------------------------------------------------------------
    logic [2:0] wsync_q;
    logic       wr_fire;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) wsync_q <= '0;
        else         wsync_q <= {wsync_q[1:0], HOST_nCS | HOST_nWE};
    end

    assign wr_fire = wsync_q[2] & ~wsync_q[1] & HOST_nOE;

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [3:0] reg_idx;
    logic       reg_hit;
    logic       cmd_wr, st_wr;

    assign reg_idx = addr[5:2];
    assign reg_hit = (addr[19:6] == '0) && !addr[0] && (32'(reg_idx) < NUM_REGS);
    assign cmd_wr  = wr_fire && (addr == ADDR_CMD);
    assign st_wr   = wr_fire && (addr == ADDR_STATUS);

    // ---------------------------------------------------------------
    // Constant register bank, 16-bit halves written independently
    // ---------------------------------------------------------------
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [31:0] val_q;
        always_ff @(posedge clk or negedge nRESET) begin
            if (!nRESET) begin
                val_q <= '0;
            end else if (wr_fire && reg_hit && reg_idx == 4'(i)) begin
                if (addr[1]) val_q[31:16] <= HDI;
                else         val_q[15:0]  <= HDI;
            end
        end
        assign const_bus[32*i +: 32] = val_q;
    end

    // ---------------------------------------------------------------
    // Command handshake. A write while a command is pending and not
    // being accepted is dropped and flagged as overrun (sticky, W1C).
    // A write landing on the accept cycle replaces the command.
    // ---------------------------------------------------------------
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             accept;

    assign accept = valid_q & cmd_ready;

    always_comb begin
        cmd_d   = cmd_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (accept) valid_d = 1'b0;
        if (cmd_wr) begin
            if (!valid_q || accept) begin
                cmd_d   = HDI[CMD_W-1:0];
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (st_wr && HDI[ST_OVERRUN]) ovr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            cmd_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = valid_q;

    // ---------------------------------------------------------------
    // Read mux and registered read data (updates every clk while the
    // host holds nCS and nOE low, holds otherwise)
    // ---------------------------------------------------------------
    logic [15:0] status;
    logic [15:0] hdo_q, hdo_d;

    always_comb begin
        status              = '0;
        status[ST_VALID]    = valid_q;
        status[ST_OVERRUN]  = ovr_q;
        status[ST_BUSY]     = proc_busy;
    end

    always_comb begin
        hdo_d = '0;
        if (reg_hit) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (reg_idx == 4'(i))
                    hdo_d = addr[1] ? const_bus[32*i+16 +: 16] : const_bus[32*i +: 16];
        end else begin
            case (addr)
                ADDR_CMD:     hdo_d = 16'(cmd_q);
                ADDR_STATUS:  hdo_d = status;
                ADDR_DOUT_LO: hdo_d = proc_dout[15:0];
                ADDR_DOUT_HI: hdo_d = proc_dout[31:16];
                default:      hdo_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET)                    hdo_q <= '0;
        else if (!HOST_nCS && !HOST_nOE) hdo_q <= hdo_d;
    end

    assign HDO = hdo_q;

    // ---------------------------------------------------------------
    // 7-segment display of the core result
    // ---------------------------------------------------------------
    host_regbank_seg_seg_scan #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_seg_scan (
        .clk        (clk),
        .nRESET     (nRESET),
        .din_i      (proc_dout[4*NUM_DIGITS-1:0]),
        .seg_com_o  (SEG_COM),
        .seg_data_o (SEG_DATA)
    );

endmodule

// File: tb/tb_host_regbank_seg.sv
// Directed bench for host_regbank_seg (SCAN_DIV shortened to 4).
module tb_host_regbank_seg;

    localparam int NR = 4;
    localparam int ND = 6;
    localparam int SD = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              nRESET = 1'b0;
    logic              HOST_nCS = 1'b1, HOST_nWE = 1'b1, HOST_nOE = 1'b1;
    logic [20:0]       HOST_ADD = '0;
    logic [15:0]       HDI = '0;
    logic [15:0]       HDO;
    logic [NR*32-1:0]  const_bus;
    logic [CW-1:0]     cmd;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [31:0]       proc_dout = '0;
    logic              proc_busy = 1'b0;
    logic [ND-1:0]     SEG_COM;
    logic [7:0]        SEG_DATA;

    int n_cmp = 0;
    int n_bad = 0;

    host_regbank_seg #(.NUM_REGS(NR), .NUM_DIGITS(ND), .SCAN_DIV(SD), .CMD_W(CW)) dut (
        .clk(clk), .nRESET(nRESET), .HOST_nCS(HOST_nCS), .HOST_nWE(HOST_nWE),
        .HOST_nOE(HOST_nOE), .HOST_ADD(HOST_ADD), .HDI(HDI), .HDO(HDO),
        .const_bus(const_bus), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .proc_dout(proc_dout), .proc_busy(proc_busy), .SEG_COM(SEG_COM), .SEG_DATA(SEG_DATA)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_begin(input logic [20:0] a, input logic [15:0] d);
        @(negedge clk);
        HOST_ADD = a; HDI = d; HOST_nOE = 1'b1; HOST_nCS = 1'b0; HOST_nWE = 1'b0;
    endtask

    task automatic wr_end();
        @(negedge clk);
        HOST_nCS = 1'b1; HOST_nWE = 1'b1;
        tick(4);
    endtask

    task automatic host_write(input logic [20:0] a, input logic [15:0] d);
        wr_begin(a, d);
        tick(5);
        wr_end();
    endtask

    task automatic host_read(input logic [20:0] a, output logic [15:0] d);
        @(negedge clk);
        HOST_ADD = a; HOST_nWE = 1'b1; HOST_nCS = 1'b0; HOST_nOE = 1'b0;
        tick(1);
        d = HDO;
        @(negedge clk);
        HOST_nCS = 1'b1; HOST_nOE = 1'b1;
    endtask

    task automatic test_reset();
        tick(2);
        n_cmp++; if (HDO !== 16'h0) begin n_bad++; $display("FAIL rst_hdo got %h want 0000", HDO); end
        n_cmp++; if (const_bus !== '0) begin n_bad++; $display("FAIL rst_const got %h want 0", const_bus); end
        n_cmp++; if ({cmd_valid, cmd} !== 5'h0) begin n_bad++; $display("FAIL rst_cmd got %b want 00000", {cmd_valid, cmd}); end
        n_cmp++; if (SEG_COM !== 6'h3F || SEG_DATA !== 8'h00) begin n_bad++; $display("FAIL rst_seg got %h/%h want 3f/00", SEG_COM, SEG_DATA); end
        @(negedge clk) nRESET = 1'b1;
        tick(1);
    endtask

    task automatic test_write_readback();
        logic [15:0] d;
        host_write(21'h00000, 16'h1234);
        wr_begin(21'h00002, 16'hABCD);
        tick(2);
        n_cmp++; if (const_bus[31:0] !== 32'h0000_1234) begin n_bad++; $display("FAIL wr_early got %h want 00001234", const_bus[31:0]); end
        tick(1);
        n_cmp++; if (const_bus[31:0] !== 32'hABCD_1234) begin n_bad++; $display("FAIL wr_3clk got %h want abcd1234", const_bus[31:0]); end
        tick(2);
        wr_end();
        host_read(21'h00000, d);
        n_cmp++; if (d !== 16'h1234) begin n_bad++; $display("FAIL rd_lo got %h want 1234", d); end
        host_read(21'h00002, d);
        n_cmp++; if (d !== 16'hABCD) begin n_bad++; $display("FAIL rd_hi got %h want abcd", d); end
    endtask

    task automatic test_write_once();
        wr_begin(21'h00004, 16'h1111);
        tick(5);
        @(negedge clk) HDI = 16'h2222;
        tick(15);
        wr_end();
        n_cmp++; if (const_bus[63:32] !== 32'h0000_1111) begin n_bad++; $display("FAIL wr_once got %h want 00001111", const_bus[63:32]); end
    endtask

    task automatic test_cmd();
        logic [15:0] d;
        cmd_ready = 1'b0;
        host_write(21'h01000, 16'h0005);
        n_cmp++; if ({cmd_valid, cmd} !== 5'b1_0101) begin n_bad++; $display("FAIL cmd_load got %b want 10101", {cmd_valid, cmd}); end
        host_write(21'h01000, 16'h0006);
        n_cmp++; if (cmd !== 4'h5) begin n_bad++; $display("FAIL cmd_drop got %h want 5", cmd); end
        host_read(21'h01002, d);
        n_cmp++; if (d !== 16'h0003) begin n_bad++; $display("FAIL st_ovr got %h want 0003", d); end
        @(negedge clk) cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL cmd_accept got %b want 0", cmd_valid); end
        host_write(21'h01002, 16'h0002);
        host_read(21'h01002, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL st_w1c got %h want 0000", d); end
        proc_busy = 1'b1;
        host_read(21'h01002, d);
        proc_busy = 1'b0;
        n_cmp++; if (d !== 16'h0004) begin n_bad++; $display("FAIL st_busy got %h want 0004", d); end
        proc_dout = 32'hDEAD_BEEF;
        host_read(21'h01004, d);
        n_cmp++; if (d !== 16'hBEEF) begin n_bad++; $display("FAIL dout_lo got %h want beef", d); end
        host_read(21'h01006, d);
        n_cmp++; if (d !== 16'hDEAD) begin n_bad++; $display("FAIL dout_hi got %h want dead", d); end
        host_read(21'h01000, d);
        n_cmp++; if (d !== 16'h0005) begin n_bad++; $display("FAIL rd_cmd got %h want 0005", d); end
    endtask

    task automatic test_cmd_accept_same();
        logic [15:0] d;
        host_write(21'h01000, 16'h0003);
        n_cmp++; if ({cmd_valid, cmd} !== 5'b1_0011) begin n_bad++; $display("FAIL cmd3 got %b want 10011", {cmd_valid, cmd}); end
        wr_begin(21'h01000, 16'h0009);
        tick(2);
        @(negedge clk) cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        n_cmp++; if ({cmd_valid, cmd} !== 5'b1_1001) begin n_bad++; $display("FAIL cmd_same got %b want 11001", {cmd_valid, cmd}); end
        wr_end();
        host_read(21'h01002, d);
        n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL st_same got %h want 0001", d); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        wr_begin(21'h00000, 16'h5555);
        tick(1);
        @(negedge clk) nRESET = 1'b0;
        tick(1);
        n_cmp++; if (const_bus !== '0) begin n_bad++; $display("FAIL mid_const got %h want 0", const_bus); end
        n_cmp++; if ({cmd_valid, cmd} !== 5'h0) begin n_bad++; $display("FAIL mid_cmd got %b want 00000", {cmd_valid, cmd}); end
        n_cmp++; if (HDO !== 16'h0) begin n_bad++; $display("FAIL mid_hdo got %h want 0000", HDO); end
        n_cmp++; if (SEG_COM !== 6'h3F || SEG_DATA !== 8'h00) begin n_bad++; $display("FAIL mid_seg got %h/%h want 3f/00", SEG_COM, SEG_DATA); end
        @(negedge clk) nRESET = 1'b1;
        tick(5);
        n_cmp++; if (const_bus !== '0) begin n_bad++; $display("FAIL stale_wr got %h want 0", const_bus); end
        wr_end();
        proc_busy = 1'b1;
        host_read(21'h01002, d);
        proc_busy = 1'b0;
        n_cmp++; if (d !== 16'h0004) begin n_bad++; $display("FAIL post_st got %h want 0004", d); end
        host_read(21'h02000, d);
        n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL unmapped got %h want 0000", d); end
    endtask

    task automatic test_seg_scan();
        logic [5:0] exp_com [7];
        logic [7:0] exp_seg [7];
        exp_com = '{6'h1F, 6'h2F, 6'h37, 6'h3B, 6'h3D, 6'h3E, 6'h1F};
        exp_seg = '{8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E, 8'hEE};
        proc_dout = 32'h00FE_DCBA;
        @(negedge clk) nRESET = 1'b0;
        @(negedge clk) nRESET = 1'b1;
        tick(3);
        n_cmp++; if (SEG_COM !== 6'h3F) begin n_bad++; $display("FAIL seg_pre got %h want 3f", SEG_COM); end
        for (int k = 0; k < 7; k++) begin
            tick(k == 0 ? 1 : 4);
            n_cmp++;
            if (SEG_COM !== exp_com[k] || SEG_DATA !== exp_seg[k]) begin
                n_bad++;
                $display("FAIL seg_step%0d got %h/%h want %h/%h", k, SEG_COM, SEG_DATA, exp_com[k], exp_seg[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_write_once();
        test_cmd();
        test_cmd_accept_same();
        test_reset_mid();
        test_seg_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
